// File: rtl/proc_gen.sv
// Multicycle 8-register CPU core that fetches through R7 and reaches memory over
// a req/ready port, so wait-state memories and memory-mapped I/O can stall it.
package proc_gen_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_F_WAIT,
    ST_EX1,
    ST_EX2,
    ST_EX3,
    ST_I_WAIT,
    ST_L_WAIT,
    ST_S_WAIT,
    ST_DONE,
    ST_HALT
  } state_t;
endpackage

module proc_gen
  import proc_gen_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic              mem_req,
  output logic              Done,
  output logic              Halted,
  output state_t            state_dbg
);

  // Memory handshake: mem_req is high in every wait state; the access completes
  // on the first rising edge where mem_ready is also high (read data sampled
  // from DIN on that edge). mem_ready is ignored whenever mem_req is low.

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;

  state_t            state;
  logic [DATA_W-1:0] r [8];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [8:0]        ir;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  // Register value to bus address: truncate or zero-extend to ADDR_W.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [ADDR_W+DATA_W-1:0] wide;
    wide = {{ADDR_W{1'b0}}, v};
    return wide[ADDR_W-1:0];
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      for (int i = 0; i < 7; i++) r[i] <= '0;
      r[7] <= RESET_PC;
      a    <= '0;
      g    <= '0;
      ir   <= '0;
      ADDR <= '0;
      DOUT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          ADDR  <= to_addr(r[7]);
          r[7]  <= r[7] + DATA_W'(1);
          state <= ST_F_WAIT;
        end
        ST_F_WAIT: begin
          if (mem_ready) begin
            ir    <= DIN[DATA_W-1 -: 9];
            state <= ST_EX1;
          end
        end
        ST_EX1: begin
          case (op)
            OP_MV: begin
              r[rx] <= r[ry];
              state <= ST_DONE;
            end
            OP_MVI: begin
              // Immediate lives in the word after the opcode.
              ADDR  <= to_addr(r[7]);
              r[7]  <= r[7] + DATA_W'(1);
              state <= ST_I_WAIT;
            end
            OP_ADD, OP_SUB: begin
              a     <= r[rx];
              state <= ST_EX2;
            end
            OP_LD: begin
              ADDR  <= to_addr(r[ry]);
              state <= ST_L_WAIT;
            end
            OP_ST: begin
              ADDR  <= to_addr(r[ry]);
              DOUT  <= r[rx];
              state <= ST_S_WAIT;
            end
            OP_MVNZ: begin
              if (g != '0) r[rx] <= r[ry];
              state <= ST_DONE;
            end
            default: state <= ST_HALT;
          endcase
        end
        ST_EX2: begin
          g     <= (op == OP_SUB) ? a - r[ry] : a + r[ry];
          state <= ST_EX3;
        end
        ST_EX3: begin
          r[rx] <= g;
          state <= ST_DONE;
        end
        ST_I_WAIT, ST_L_WAIT: begin
          if (mem_ready) begin
            r[rx] <= DIN;
            state <= ST_DONE;
          end
        end
        ST_S_WAIT: begin
          if (mem_ready) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= Run ? ST_FETCH : ST_IDLE;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode the state register alone, so Reset drops them at once.
  assign mem_req   = (state == ST_F_WAIT) || (state == ST_I_WAIT) ||
                     (state == ST_L_WAIT) || (state == ST_S_WAIT);
  assign W         = (state == ST_S_WAIT);
  assign Done      = (state == ST_DONE);
  assign Halted    = (state == ST_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_proc_gen.sv
// Bench for proc_gen: instruction-level model plus a bus responder, checked
// cycle by cycle, with directed programs and hand-computed expectations.
module tb_proc_gen;
  import proc_gen_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Run = 1'b0;
  logic [DW-1:0] DIN = '0;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DOUT;
  logic          W;
  logic          mem_req;
  logic          Done;
  logic          Halted;
  state_t        state_dbg;

  proc_gen #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(16'h0010)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .mem_ready(mem_ready),
    .ADDR(ADDR), .DOUT(DOUT), .W(W), .mem_req(mem_req), .Done(Done),
    .Halted(Halted), .state_dbg(state_dbg)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bench memory seen by the DUT, and the model's own copy.
  bit [15:0] mem   [0:65535];
  bit [15:0] m_mem [0:65535];

  function automatic logic [15:0] enc(input int op, input int rx, input int ry);
    logic [2:0] o, x, y;
    o = 3'(op); x = 3'(rx); y = 3'(ry);
    return {o, x, y, 7'b0};
  endfunction

  task automatic put(input logic [15:0] a, input logic [15:0] d);
    mem[a] = d;
    m_mem[a] = d;
  endtask

  // Responder: extra wait cycles per access, optional noise on mem_ready when idle.
  int wait_n = 0;
  bit noise = 0;
  int req_cnt = 0;
  always @(posedge Clock) begin
    #3;
    mem_ready = 1'b0;
    if (mem_req) begin
      if (req_cnt >= wait_n) begin
        mem_ready = 1'b1;
        req_cnt = 0;
        if (W) mem[ADDR] = DOUT;
        else DIN = mem[ADDR];
      end else req_cnt++;
    end else begin
      req_cnt = 0;
      if (noise) begin
        mem_ready = 1'($urandom_range(0, 1));
        DIN = 16'($urandom);
      end
    end
  end

  // Instruction-level model
  typedef struct packed {
    logic [15:0] addr;
    logic        w;
    logic [15:0] data;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] m_r [0:7];
  logic [15:0] m_g;
  bit          m_halted;
  bit          is_halt;
  int          exp_cyc;

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_r[i] = '0;
    m_r[7] = 16'h0010;
    m_g = '0;
    m_halted = 0;
    acc_q.delete();
  endtask

  // Executes one whole instruction; exp_cyc = FETCH..DONE cycles for this wait_n.
  task automatic model_step();
    logic [15:0] iw, pc, t;
    logic [2:0]  op, rx, ry;
    pc = m_r[7];
    iw = m_mem[pc];
    acc_q.push_back('{addr: pc, w: 1'b0, data: 16'h0});
    m_r[7] = pc + 16'd1;
    op = iw[15:13]; rx = iw[12:10]; ry = iw[9:7];
    is_halt = 0;
    case (op)
      3'd0: begin m_r[rx] = m_r[ry]; exp_cyc = 4 + wait_n; end
      3'd1: begin
        t = m_r[7];
        acc_q.push_back('{addr: t, w: 1'b0, data: 16'h0});
        m_r[7] = t + 16'd1;
        m_r[rx] = m_mem[t];
        exp_cyc = 5 + 2 * wait_n;
      end
      3'd2: begin m_g = m_r[rx] + m_r[ry]; m_r[rx] = m_g; exp_cyc = 6 + wait_n; end
      3'd3: begin m_g = m_r[rx] - m_r[ry]; m_r[rx] = m_g; exp_cyc = 6 + wait_n; end
      3'd4: begin
        t = m_r[ry];
        acc_q.push_back('{addr: t, w: 1'b0, data: 16'h0});
        m_r[rx] = m_mem[t];
        exp_cyc = 5 + 2 * wait_n;
      end
      3'd5: begin
        t = m_r[ry];
        acc_q.push_back('{addr: t, w: 1'b1, data: m_r[rx]});
        m_mem[t] = m_r[rx];
        exp_cyc = 5 + 2 * wait_n;
      end
      3'd6: begin if (m_g != 16'h0) m_r[rx] = m_r[ry]; exp_cyc = 4 + wait_n; end
      default: begin m_halted = 1; is_halt = 1; exp_cyc = 4 + wait_n; end
    endcase
  endtask

  // Compare process
  bit chk_en = 0;
  bit in_instr = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(negedge Clock) begin
    if (chk_en) begin
      cyc++;
      if (mem_req && !in_instr) begin
        model_step();
        in_instr = 1;
        start_cyc = cyc - 1;
      end
      if (mem_req) begin
        if (acc_q.size() == 0) chk("acc_extra", mem_req, 1'b0);
        else begin
          chk("acc_addr", ADDR, acc_q[0].addr);
          chk("acc_w", W, acc_q[0].w);
          if (acc_q[0].w) chk("acc_dout", DOUT, acc_q[0].data);
          if (mem_ready) void'(acc_q.pop_front());
        end
      end else chk("w_no_req", W, 1'b0);
      chk("done_timing", Done, in_instr && !is_halt && cyc == start_cyc + exp_cyc - 1);
      chk("halted", Halted, m_halted && !(in_instr && cyc < start_cyc + exp_cyc - 1));
      if (in_instr && cyc == start_cyc + exp_cyc - 1) begin
        for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), dut.r[i], m_r[i]);
        chk("g", dut.g, m_g);
        chk("acc_left", acc_q.size(), 0);
        in_instr = 0;
      end
    end
  end

  task automatic wait_done(input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge Clock);
      if (Done) got = 1;
    end
    chk(name, got, 1'b1);
  endtask

  initial begin
    int d[$];
    int w_cnt, last_w, done_c;
    bit got;

    put(16'h0010, enc(1, 0, 0)); put(16'h0011, 16'd5);
    put(16'h0012, enc(2, 0, 0));
    put(16'h0013, enc(1, 1, 0)); put(16'h0014, 16'd3);
    put(16'h0015, enc(1, 2, 0)); put(16'h0016, 16'd5);
    put(16'h0017, enc(3, 1, 2));
    put(16'h0018, enc(6, 3, 1));
    put(16'h0019, enc(3, 2, 2));
    put(16'h001A, enc(6, 3, 0));
    put(16'h001B, enc(1, 4, 0)); put(16'h001C, 16'h1234);
    put(16'h001D, enc(1, 5, 0)); put(16'h001E, 16'h1000);
    put(16'h001F, enc(5, 4, 5));
    put(16'h0020, enc(1, 6, 0)); put(16'h0021, 16'h0040);
    put(16'h0022, enc(0, 7, 6));
    put(16'h0040, enc(0, 1, 7));
    put(16'h0041, enc(4, 2, 5));
    put(16'h0042, enc(7, 0, 0));
    model_reset();

    repeat (2) @(negedge Clock);
    chk("rst_addr", ADDR, 16'h0);
    chk("rst_dout", DOUT, 16'h0);
    chk("rst_w", W, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_r7", dut.r[7], 16'h0010);
    chk("rst_r0", dut.r[0], 16'h0);

    Run = 1; Reset = 0; chk_en = 1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clock);
      if (c == 1) chk("fetch_no_req", mem_req, 1'b0);
      if (c == 2) begin
        chk("first_addr", ADDR, 16'h0010);
        chk("first_req", mem_req, 1'b1);
      end
      if (Done) d.push_back(c);
    end
    chk("done_count", d.size(), 2);
    if (d.size() == 2) begin
      chk("done1_cycle", d[0], 5);
      chk("done2_cycle", d[1], 11);
    end
    chk("add_r0", dut.r[0], 16'h000A);
    chk("add_g", dut.g, 16'h000A);

    repeat (4) wait_done("wd_sub");
    chk("sub_r1", dut.r[1], 16'hFFFE);
    chk("sub_g", dut.g, 16'hFFFE);
    chk("mvnz_r3", dut.r[3], 16'hFFFE);
    repeat (2) wait_done("wd_mvnz0");
    chk("mvnz0_r3", dut.r[3], 16'hFFFE);
    chk("mvnz0_g", dut.g, 16'h0);
    repeat (2) wait_done("wd_mvi45");
    chk("mvi_r4", dut.r[4], 16'h1234);
    chk("mvi_r5", dut.r[5], 16'h1000);

    wait_n = 2;
    w_cnt = 0; last_w = 0; done_c = 0;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge Clock);
      if (c == 3) Run = 0;
      if (W) begin
        w_cnt++;
        last_w = c;
        chk("st_addr", ADDR, 16'h1000);
        chk("st_dout", DOUT, 16'h1234);
      end
      if (Done) done_c = c;
    end
    chk("st_w_cycles", w_cnt, 3);
    chk("st_done_cycle", done_c, 9);
    chk("st_done_after_ready", done_c, last_w + 1);
    @(negedge Clock);
    chk("run_off_idle", state_dbg, ST_IDLE);
    @(negedge Clock);
    chk("run_off_stay", state_dbg, ST_IDLE);
    chk("run_off_req", mem_req, 1'b0);
    chk("st_mem", mem[16'h1000], 16'h1234);

    wait_n = 0; noise = 1; Run = 1;
    wait_done("wd_mvi6");
    wait_done("wd_jump");
    @(negedge Clock);
    chk("jump_fetch_req", mem_req, 1'b0);
    @(negedge Clock);
    chk("jump_addr", ADDR, 16'h0040);
    chk("jump_req", mem_req, 1'b1);
    wait_done("wd_mv_r7src");
    chk("r7src_r1", dut.r[1], 16'h0041);
    wait_done("wd_ld");
    chk("ld_r2", dut.r[2], 16'h1234);

    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clock);
      if (Halted) got = 1;
    end
    chk("halt_reached", got, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      chk("halt_hold", {Halted, mem_req, Done}, 3'b100);
    end
    chk_en = 0;
    #1 Reset = 1;
    #1;
    chk("halt_cleared", Halted, 1'b0);
    chk("halt_rst_state", state_dbg, ST_IDLE);
    chk("halt_rst_r7", dut.r[7], 16'h0010);

    put(16'h0010, enc(4, 1, 2));
    put(16'h0000, 16'hBEEF);
    noise = 0; wait_n = 0; Run = 1;
    @(negedge Clock);
    Reset = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clock);
      if (mem_req && ADDR == 16'h0010) got = 1;
    end
    chk("l_fetch_seen", got, 1'b1);
    wait_n = 50;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clock);
      if (mem_req && ADDR == 16'h0000) got = 1;
    end
    chk("l_wait_seen", got, 1'b1);
    chk("l_wait_req", mem_req, 1'b1);
    #1 Reset = 1;
    #1;
    chk("l_rst_req", mem_req, 1'b0);
    chk("l_rst_w", W, 1'b0);
    chk("l_rst_state", state_dbg, ST_IDLE);
    chk("l_rst_r1", dut.r[1], 16'h0);
    @(negedge Clock);
    Reset = 0; Run = 0;
    @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/proc_gen.md
Name: proc_gen

Overview:
- Parametrised next-generation multicycle CPU core for the FPGA processor system.
- Fetches its own instructions through R7, which acts as the program counter, instead of taking instructions from an external counter.
- Talks to memory and memory-mapped I/O through an address/data port with a req/ready handshake, so wait-state memories work.
- Adds a HALT opcode; the chip-select decoder and LED register sit outside this block, unchanged.

Parameters:
- DATA_W, 16, register/bus width; must be >= 9.
- ADDR_W, 16, ADDR width; ADDR = register value truncated or zero-extended to ADDR_W.
- RESET_PC, 0, value loaded into R7 on reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears the whole core.
- Run  in  1  start/continue execution.
- DIN  in  DATA_W  read data from memory; instruction is taken from DIN[DATA_W-1 -: 9] as {opcode[2:0], RX[2:0], RY[2:0]}.
- mem_ready  in  1  memory has completed the current request; DIN is valid this cycle for reads.
- ADDR  out  ADDR_W  registered memory address.
- DOUT  out  DATA_W  registered store data.
- W  out  1  write strobe; high during a store request.
- mem_req  out  1  request active; high in every wait state.
- Done  out  1  one-cycle pulse when an instruction retires.
- Halted  out  1  core has stopped on a HALT instruction.

Behaviour:
- Reset (async): state=IDLE, R0-R6=0, R7=RESET_PC, A=G=IR=0, ADDR=0, DOUT=0, W=0, mem_req=0, Done=0, Halted=0. W and mem_req drop immediately, even in the middle of an access.
- Outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded.
- States and transitions:
- IDLE: if Run=1, go to FETCH.
- FETCH: ADDR<=R7; R7<=R7+1; go to F_WAIT.
- F_WAIT: mem_req=1. On mem_ready: IR<=instr field of DIN; go to EX1. Otherwise stay (unbounded wait).
- EX1, by opcode:
  - 000 mv: Rx<=Ry; go to DONE.
  - 001 mvi: ADDR<=R7; R7<=R7+1; go to I_WAIT. I_WAIT: mem_req=1; on mem_ready, Rx<=DIN; go to DONE. The immediate is the next word.
  - 010 add / 011 sub: A<=Rx; go to EX2. EX2: G<=A+Ry (add) or A-Ry (sub), i.e. Rx-Ry; go to EX3. EX3: Rx<=G; go to DONE.
  - 100 ld: ADDR<=Ry; go to L_WAIT. L_WAIT: mem_req=1; on mem_ready, Rx<=DIN; go to DONE.
  - 101 st: ADDR<=Ry; DOUT<=Rx; go to S_WAIT. S_WAIT: mem_req=1, W=1; on mem_ready, go to DONE. W is low everywhere else.
  - 110 mvnz: if G!=0 then Rx<=Ry; go to DONE. G is not changed.
  - 111 halt: go to HALT.
- DONE: Done=1. If Run=1 go to FETCH, else go to IDLE.
- HALT: Halted=1, Done=0. Stays in HALT until Reset; Run is ignored.
- Cycle counts, zero-wait memory (mem_ready high in the first wait cycle), FETCH through DONE inclusive:
  - mv, mvnz: 4 cycles.
  - mvi, ld, st: 5 cycles.
  - add, sub: 6 cycles.
  - Each extra wait cycle adds 1.
- R7 as destination: an explicit write to R7 (mv, mvi, ld, add/sub EX3) acts as a jump. Writes are never in the same cycle as an R7 increment, so no conflict exists.
- R7 as source: reads return the already-incremented PC, i.e. the address of the next word.
- mem_ready while mem_req=0 is ignored.
- Run deasserted mid-instruction: the instruction completes (including pending waits), then the core goes to IDLE.

Test Plan:
- Reset: Reset=1 with RESET_PC=0x0010 -> all outputs 0, R7=0x0010. Release Reset, Run=1 -> next cycle ADDR=0x0010, then mem_req=1.
- mvi R0,#5 then add R0,R0 (zero-wait memory) -> Done pulses at cycle 5 and cycle 11; R0=0x000A; G=0x000A.
- sub wrap: R1=3, R2=5, sub R1,R2 -> R1=0xFFFE (DATA_W=16). Follow with mvnz R3,R1 -> R3=0xFFFE. Set G=0 first instead -> R3 unchanged.
- st R4,R5 with R4=0x1234, R5=0x1000, mem_ready delayed 3 cycles -> ADDR=0x1000, DOUT=0x1234; W and mem_req high for exactly 3 cycles; Done follows the cycle after ready.
- mv R7,R6 (R6=0x0040) -> the next FETCH drives ADDR=0x0040. Next, a halt instruction -> Halted=1 and the core stays there with Run=1 for 20 cycles; Reset clears Halted.
- Reset asserted during L_WAIT -> mem_req drops asynchronously, state=IDLE, destination register unchanged.
